// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths and FSM state type for the icache refill engine
//
// Purpose: single home for the line geometry (16-bit words, 4 words per line)
// and the refill FSM state encoding used by icache_refill.
// Ports: none (package).
package icache_pkg;

  localparam int WORD_W     = 16;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = WORD_W * LINE_WORDS;
  localparam int TAG_W      = 10;
  localparam int INDEX_W    = 3;
  localparam int ADDR_W     = WORD_W;
  localparam int OFFSET_W   = ADDR_W - TAG_W - INDEX_W;

  // Clears the byte/word offset bits, leaving {tag, index, 000}.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFFSET_W) - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_t;

endpackage

// File: rtl/icache_refill_timer.sv
// rtl/icache_refill_timer.sv - clearable per-word wait counter with expiry flag
//
// Purpose: counts cycles spent waiting for memory on the current word.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   clear   - forces the count back to zero (idle, or word accepted)
//   enable  - count one cycle while waiting
//   expired - high once the count has reached TIMEOUT
module icache_refill_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT));

  // Stops at TIMEOUT so the flag can never be lost to a wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction cache line refill engine
//
// Purpose: on a fetch miss, reads the four 16-bit words of the missing line
// from instruction memory, assembles them and presents one line write strobe.
// A per-word timeout aborts the refill with an error pulse.
// Optional feature macro: ICACHE_REFILL_PERF_EN adds a saturating miss counter.
// Ports:
//   inp_clk, inp_rst                 - clock, synchronous active-high reset
//   inp_fetchReq, inp_address, inp_hit - fetch stage lookup (sampled in IDLE only)
//   out_memRead, out_memAddress      - word read request, held until accepted
//   inp_memReady, inp_memData        - accept + returned word, same cycle
//   out_lineValid, out_lineAddress, out_lineData - line write (one-cycle strobe)
//   out_stall                        - freezes fetch while refilling
//   out_error                        - one-cycle pulse on memory timeout
//   out_missCount                    - (ICACHE_REFILL_PERF_EN only) miss count
module icache_refill
  import icache_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              inp_clk,
  input  logic              inp_rst,
  input  logic              inp_fetchReq,
  input  logic [ADDR_W-1:0] inp_address,
  input  logic              inp_hit,
  output logic              out_memRead,
  output logic [ADDR_W-1:0] out_memAddress,
  input  logic              inp_memReady,
  input  logic [WORD_W-1:0] inp_memData,
  output logic              out_lineValid,
  output logic [ADDR_W-1:0] out_lineAddress,
  output logic [LINE_W-1:0] out_lineData,
  output logic              out_stall,
  output logic              out_error
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [15:0]       out_missCount
`endif
);

  state_t state;
  state_t state_next;

  logic [ADDR_W-1:0]          base_addr;
  logic [1:0]                 word_cnt;
  logic [LINE_W-WORD_W-1:0]   line_buf;   // words 0..2; word 3 goes straight out
  logic [LINE_W-1:0]          line_data_q;
  logic [ADDR_W-1:0]          line_addr_q;
  logic                       error_q;
  logic                       timer_expired;

  logic miss;
  logic accept;
  logic last_word;
  logic timeout;

  assign miss      = (state == IDLE) && inp_fetchReq && !inp_hit;
  assign accept    = (state == FETCH) && inp_memReady;
  assign last_word = accept && (word_cnt == 2'd3);
  assign timeout   = (state == FETCH) && !inp_memReady && timer_expired;

  icache_refill_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (inp_clk),
    .rst    (inp_rst),
    .clear  ((state != FETCH) || inp_memReady),
    .enable (state == FETCH),
    .expired(timer_expired)
  );

  // State register
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (miss) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        // A word accepted in the same cycle the timer expires still counts.
        if (last_word) begin
          state_next = DELIVER;
        end else if (timeout) begin
          state_next = IDLE;
        end
      end
      DELIVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_memRead     = 1'b0;
    out_memAddress  = '0;
    out_lineValid   = 1'b0;
    out_stall       = 1'b0;
    unique case (state)
      IDLE: begin
      end
      FETCH: begin
        out_memRead    = 1'b1;
        out_memAddress = base_addr + {{(ADDR_W-3){1'b0}}, word_cnt, 1'b0};
        out_stall      = 1'b1;
      end
      DELIVER: begin
        out_lineValid = 1'b1;
        out_stall     = 1'b1;
      end
      default: begin
      end
    endcase
    out_lineAddress = line_addr_q;
    out_lineData    = line_data_q;
    out_error       = error_q;
  end

  // Refill datapath. The delivered line registers only change on the final
  // word, so an aborted refill never disturbs the previously delivered line.
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      base_addr   <= '0;
      word_cnt    <= '0;
      line_buf    <= '0;
      line_data_q <= '0;
      line_addr_q <= '0;
      error_q     <= 1'b0;
    end else begin
      error_q <= timeout;
      if (miss) begin
        base_addr <= inp_address & LINE_MASK;
        word_cnt  <= '0;
      end
      if (accept) begin
        word_cnt <= word_cnt + 2'd1;
        unique case (word_cnt)
          2'd0: line_buf[WORD_W-1:0]          <= inp_memData;
          2'd1: line_buf[2*WORD_W-1:WORD_W]   <= inp_memData;
          2'd2: line_buf[3*WORD_W-1:2*WORD_W] <= inp_memData;
          2'd3: begin
            line_data_q <= {inp_memData, line_buf};
            line_addr_q <= base_addr;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef ICACHE_REFILL_PERF_EN
  logic [15:0] miss_count;

  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      miss_count <= '0;
    end else if (miss && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'd1;
    end
  end

  assign out_missCount = miss_count;
`endif

endmodule
